figure_select_ctrl: RTL and testbench
=====================================

# figure_select_ctrl

Frame-synchronous selection controller for the 3x3 figure grid of the 640x480 VGA display. Accepts single-cycle button pulses, maintains a cursor cell and a 9-bit figure-enable mask, and auto-cycles the cursor in a timed mode. All visible changes are applied only at the start of vertical blanking, which prevents tearing. Sits between the button debouncers and the figure/colour mux, alongside the pixel counters.

## Interface
Parameters:
- DWELL_FRAMES, 60: frames per cursor step in AUTO mode (legal range 1..255).
- FRAME_LINE, 480: VCount value that marks the start of vertical blanking.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- HCount  in  10  current pixel column from the VGA sync generator.
- VCount  in  10  current pixel line from the VGA sync generator.
- btn_up, btn_down, btn_left, btn_right  in  1 each  one-clk debounced pulses.
- btn_toggle  in  1  one-clk pulse: invert the enable bit of the cursor cell.
- btn_mode  in  1  one-clk pulse: switch between MANUAL and AUTO.
- cell_idx  out  4  cursor cell, row*3+col, range 0..8.
- fig_mask  out  9  bit i = figure in cell i enabled.
- auto_mode  out  1  1 = AUTO state.
- cursor_on  out  1  current pixel lies on the cursor outline (registered).

## Operation
- Cells: columns x∈[0,211], [215,425], [429,639]; rows y∈[0,157], [162,318], [323,479]; these match the grid border positions.
- frame_start: a registered flag of (VCount==FRAME_LINE && HCount==0). frame_start pulses for exactly one clk on the rising edge of that flag, regardless of how many clks each pixel lasts.
- Command latch: a 3-bit pending register holds one of NONE, UP, DOWN, LEFT, RIGHT, TOGGLE, MODE.
  - A command is captured only while pending==NONE. Later pulses in the same frame are dropped.
  - Simultaneous pulses in one clk are resolved by priority: MODE > TOGGLE > UP > DOWN > LEFT > RIGHT.
  - pending is cleared on the frame_start clk. A pulse arriving on that same clk is captured as the next pending command.
- FSM with states MANUAL and AUTO. On the frame_start clk:
  - MANUAL:
    - UP/DOWN: row ∓1 mod 3.
    - LEFT/RIGHT: col ∓1 mod 3. Row is unchanged, so this is wrap within the row.
    - TOGGLE: fig_mask[cell_idx] inverted.
    - MODE: go to AUTO and clear dwell_cnt.
  - AUTO:
    - Only MODE is honoured: go to MANUAL and clear dwell_cnt. Other commands are discarded.
    - Otherwise, if dwell_cnt==DWELL_FRAMES-1: cell_idx = (cell_idx+1) mod 9 (8→0) and dwell_cnt=0. Else dwell_cnt+1.
- dwell_cnt is 8 bits and is only incremented in AUTO.
- cursor_on is 1 when (x,y) lies in the cursor cell and within 3 px of any edge of that cell: x≤xl+2, x≥xr−2, y≤yt+2 or y≥yb−2. It is 0 for border pixels and for x>639 or y>479. It is active in both modes.

## Timing
- Reset values:
  - cell_idx=0, fig_mask=9'h1FF, auto_mode=0, cursor_on=0.
  - pending=NONE, dwell_cnt=0, frame_start flag=0.
- Reset mid-frame discards any pending command. Reset dominates every other input.
- frame_start latency: 1 clk after the condition first becomes true.
- State update happens on the edge that samples frame_start=1. cell_idx, fig_mask and auto_mode change on that edge and are stable for the whole next frame.
- Command latency: between 1 clk and 1 frame from the button pulse to the output change. There is never more than one applied command per frame.
- cursor_on has 1-clk latency from HCount/VCount. It uses the cell_idx register value, not any pending value.

## Test plan
- Reset, then 2 frames with no buttons → cell_idx=0, fig_mask=1FF, auto_mode=0. cursor_on=1 at (0,0) and at (211,100); 0 at (100,100) and at (212,0).
- btn_right at VCount=100 → cell_idx still 0 until the frame_start edge, then 1. Three more btn_right pulses in separate frames → 2, 0, 1 (wrap within the row).
- btn_up then btn_left in the same frame from idx 0 → only UP applied: idx=6 (row 2). Next frame, no change.
- btn_toggle and btn_down on the same clk at idx 4 → fig_mask=1EF and idx stays 4. A second toggle the next frame → 1FF.
- btn_mode with DWELL_FRAMES=2 from idx 7 → auto_mode=1 at the next frame_start. idx then reads 7, 7, 8, 8, 0 over the following frames. btn_up in AUTO is ignored. btn_mode → auto_mode=0 and idx frozen.
- Assert reset for 1 clk while a command is pending and during AUTO → all outputs return to reset values and the pending command never applies.

Source files
------------

// File: rtl/figure_select_ctrl.sv
// figure_select_ctrl: frame-synchronous cursor/mask controller for the 3x3 VGA figure grid
module figure_select_ctrl #(
  parameter int DWELL_FRAMES = 60,
  parameter int FRAME_LINE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] HCount,
  input  logic [9:0] VCount,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_toggle,
  input  logic       btn_mode,
  output logic [3:0] cell_idx,
  output logic [8:0] fig_mask,
  output logic       auto_mode,
  output logic       cursor_on
);
  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT, TOGGLE, MODE} cmd_t;
  typedef enum logic {MANUAL, AUTO} state_t;
  state_t state;
  cmd_t pending, cmd;
  logic [1:0] row, col;
  logic [7:0] dwell_cnt;
  logic fs_flag, fs_prev, frame_start, in_cell, on_edge;
  logic [9:0] xl, xr, yt, yb;
  assign frame_start = fs_flag & ~fs_prev;
  assign cell_idx = 4'(row) * 4'd3 + 4'(col);
  assign auto_mode = state == AUTO;
  always_comb begin
    cmd = btn_mode ? MODE : btn_toggle ? TOGGLE : btn_up ? UP : btn_down ? DOWN :
          btn_left ? LEFT : btn_right ? RIGHT : NONE;
    xl = col == 2'd0 ? 10'd0 : col == 2'd1 ? 10'd215 : 10'd429;
    xr = col == 2'd0 ? 10'd211 : col == 2'd1 ? 10'd425 : 10'd639;
    yt = row == 2'd0 ? 10'd0 : row == 2'd1 ? 10'd162 : 10'd323;
    yb = row == 2'd0 ? 10'd157 : row == 2'd1 ? 10'd318 : 10'd479;
    in_cell = HCount >= xl && HCount <= xr && VCount >= yt && VCount <= yb;
    on_edge = HCount <= xl + 10'd2 || HCount >= xr - 10'd2 ||
              VCount <= yt + 10'd2 || VCount >= yb - 10'd2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MANUAL;
      pending <= NONE;
      row <= '0;
      col <= '0;
      dwell_cnt <= '0;
      fig_mask <= 9'h1FF;
      fs_flag <= 1'b0;
      fs_prev <= 1'b0;
      cursor_on <= 1'b0;
    end else begin
      fs_flag <= VCount == 10'(FRAME_LINE) && HCount == 10'd0;
      fs_prev <= fs_flag;
      cursor_on <= in_cell && on_edge;
      if (frame_start || pending == NONE) pending <= cmd;
      if (frame_start) begin
        if (state == MANUAL) begin
          if (pending == UP) row <= row == 2'd0 ? 2'd2 : row - 2'd1;
          if (pending == DOWN) row <= row == 2'd2 ? 2'd0 : row + 2'd1;
          if (pending == LEFT) col <= col == 2'd0 ? 2'd2 : col - 2'd1;
          if (pending == RIGHT) col <= col == 2'd2 ? 2'd0 : col + 2'd1;
          if (pending == TOGGLE) fig_mask[cell_idx] <= ~fig_mask[cell_idx];
          if (pending == MODE) begin
            state <= AUTO;
            dwell_cnt <= '0;
          end
        end else if (pending == MODE) begin
          state <= MANUAL;
          dwell_cnt <= '0;
        end else if (dwell_cnt == 8'(DWELL_FRAMES - 1)) begin
          dwell_cnt <= '0;
          col <= col == 2'd2 ? 2'd0 : col + 2'd1;
          if (col == 2'd2) row <= row == 2'd2 ? 2'd0 : row + 2'd1;
        end else dwell_cnt <= dwell_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_figure_select_ctrl.sv
// tb_figure_select_ctrl: directed self-checking bench for figure_select_ctrl
module tb_figure_select_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] HCount = '0, VCount = '0;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_toggle = 0, btn_mode = 0;
  logic [3:0] cell_idx;
  logic [8:0] fig_mask;
  logic auto_mode, cursor_on;
  int checks = 0, errors = 0;
  figure_select_ctrl #(.DWELL_FRAMES(2), .FRAME_LINE(480)) dut (
    .clk(clk), .reset(reset), .HCount(HCount), .VCount(VCount),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_toggle(btn_toggle), .btn_mode(btn_mode),
    .cell_idx(cell_idx), .fig_mask(fig_mask), .auto_mode(auto_mode), .cursor_on(cursor_on)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // bits: {mode, toggle, up, down, left, right}
  task automatic press(input logic [5:0] b);
    {btn_mode, btn_toggle, btn_up, btn_down, btn_left, btn_right} = b;
    tick();
    {btn_mode, btn_toggle, btn_up, btn_down, btn_left, btn_right} = '0;
  endtask
  task automatic frame();
    HCount = 10'd0;
    VCount = 10'd480;
    tick();
    VCount = 10'd481;
    tick();
    VCount = 10'd100;
    tick();
  endtask
  task automatic pix(input int x, input int y, input logic exp, input string tag);
    HCount = 10'(x);
    VCount = 10'(y);
    tick();
    check(tag, 16'(cursor_on), 16'(exp));
  endtask
  task automatic step(input logic [5:0] b, input int idx, input string tag);
    press(b);
    frame();
    check(tag, 16'(cell_idx), 16'(idx));
  endtask
  initial begin
    tick();
    tick();
    check("rst_idx", 16'(cell_idx), 16'd0);
    check("rst_mask", 16'(fig_mask), 16'h1FF);
    check("rst_auto", 16'(auto_mode), 16'd0);
    check("rst_cursor", 16'(cursor_on), 16'd0);
    reset = 1'b0;
    frame();
    frame();
    check("idle_idx", 16'(cell_idx), 16'd0);
    check("idle_mask", 16'(fig_mask), 16'h1FF);
    check("idle_auto", 16'(auto_mode), 16'd0);
    pix(0, 0, 1'b1, "cur_0_0");
    pix(211, 100, 1'b1, "cur_211_100");
    pix(100, 100, 1'b0, "cur_100_100");
    pix(212, 0, 1'b0, "cur_212_0");
    pix(700, 0, 1'b0, "cur_offscreen");
    VCount = 10'd100;
    press(6'b000001);
    tick();
    check("right_wait", 16'(cell_idx), 16'd0);
    frame();
    check("right1", 16'(cell_idx), 16'd1);
    step(6'b000001, 2, "right2");
    step(6'b000001, 0, "right3_wrap");
    step(6'b000001, 1, "right4");
    step(6'b000010, 0, "left_back");
    press(6'b001000);
    step(6'b000010, 6, "up_then_left");
    frame();
    check("up_hold", 16'(cell_idx), 16'd6);
    pix(0, 323, 1'b1, "cur6_tl");
    pix(100, 400, 1'b0, "cur6_mid");
    pix(0, 0, 1'b0, "cur6_other");
    step(6'b001000, 3, "up_to3");
    step(6'b000001, 4, "right_to4");
    step(6'b010100, 4, "toggle_down_idx");
    check("toggle_mask", 16'(fig_mask), 16'h1EF);
    step(6'b010000, 4, "toggle2_idx");
    check("toggle2_mask", 16'(fig_mask), 16'h1FF);
    // pulse on the frame_start clk becomes the next frame's command
    HCount = 10'd0;
    VCount = 10'd480;
    tick();
    VCount = 10'd481;
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    VCount = 10'd100;
    tick();
    check("fs_pulse_hold", 16'(cell_idx), 16'd4);
    frame();
    check("fs_pulse_apply", 16'(cell_idx), 16'd5);
    step(6'b000100, 8, "down_to8");
    step(6'b000010, 7, "left_to7");
    step(6'b100000, 7, "mode_idx");
    check("mode_auto", 16'(auto_mode), 16'd1);
    frame();
    check("auto_a", 16'(cell_idx), 16'd7);
    frame();
    check("auto_b", 16'(cell_idx), 16'd8);
    frame();
    check("auto_c", 16'(cell_idx), 16'd8);
    frame();
    check("auto_wrap", 16'(cell_idx), 16'd0);
    step(6'b001000, 0, "auto_up_ignored");
    frame();
    check("auto_next", 16'(cell_idx), 16'd1);
    step(6'b100000, 1, "manual_idx");
    check("manual_auto", 16'(auto_mode), 16'd0);
    frame();
    check("manual_frozen", 16'(cell_idx), 16'd1);
    press(6'b010000);
    press(6'b000000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_idx", 16'(cell_idx), 16'd0);
    check("rst2_mask", 16'(fig_mask), 16'h1FF);
    check("rst2_cursor", 16'(cursor_on), 16'd0);
    frame();
    check("rst2_mask_after", 16'(fig_mask), 16'h1FF);
    step(6'b000001, 1, "rst2_live");
    step(6'b100000, 1, "auto2_idx");
    check("auto2_on", 16'(auto_mode), 16'd1);
    press(6'b100000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst3_auto", 16'(auto_mode), 16'd0);
    check("rst3_idx", 16'(cell_idx), 16'd0);
    frame();
    frame();
    frame();
    check("rst3_auto_after", 16'(auto_mode), 16'd0);
    check("rst3_idx_after", 16'(cell_idx), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
